wb_bypass_arbiter: RTL and testbench
====================================

// Module: wb_bypass_arbiter
// PURPOSE
//  Shares the single write-back port of the lane bypass buffer among NUM_REQ execution pipes.
//  Typical pipes: ALU, MAC, load return.
//  Each pipe pushes (index, data) into its own small FIFO.
//  A round-robin scheduler drains one entry per cycle into a registered WB port.
//  Draining stops while the buffer reports full or the lane is stalled.
//  Sits between the pipe outputs and the bypass buffer / register-file write-back.
// PARAMETERS
//  NUM_REQ   3   number of requesting pipes (2..8)
//  DEPTH     2   entries per requester FIFO (power of two, >=2)
// PORTS
//  clock          in   1                 clock
//  reset          in   1                 synchronous, active-high
//  I_Stall        in   1                 lane stall; no grant while high
//  I_Buff_Full    in   1                 bypass buffer full; no grant while high
//  I_Req_Index    in   dst_t[NUM_REQ]    per-pipe WB index; .v = request valid
//  I_Req_Data     in   data_t[NUM_REQ]   per-pipe WB data
//  O_Req_Ready    out  NUM_REQ           per-pipe FIFO can accept
//  O_WB_Index     out  dst_t             to buffer/RF; .v = store strobe
//  O_WB_Data      out  data_t            to buffer/RF
//  O_Grant        out  NUM_REQ           one-hot, requester drained this cycle
//  O_Busy         out  1                 any FIFO non-empty or O_WB_Index.v
// BEHAVIOUR
//  - Reset: all FIFOs emptied; RR pointer=0; O_WB_Index='0, O_WB_Data='0, O_Grant='0, O_Busy=0.
//    O_Req_Ready is all-ones from the first cycle after reset. Reset mid-operation drops queued entries silently.
//  - Enqueue: pipe i writes its FIFO at the edge where I_Req_Index[i].v & O_Req_Ready[i].
//    O_Req_Ready[i] = (count_i != DEPTH), from registered count only.
//    No pass-through: a full FIFO refuses even if it drains in the same cycle.
//  - Valid without ready: the request is dropped. Pipes must hold it, so the arbiter never loses data.
//  - Eligible(i) = count_i != 0, registered state only. An entry enqueued at edge t is eligible in cycle t+1.
//  - Grant: when ~I_Stall & ~I_Buff_Full, pick the first eligible i scanning from RR pointer upward, with wrap.
//    O_Grant is combinational one-hot. At the edge, the head of FIFO i pops and the RR pointer moves to (i+1) mod NUM_REQ.
//    With no grant the pointer holds.
//  - WB register: at a grant edge, O_WB_Index/O_WB_Data <= head entry; otherwise O_WB_Index.v <= 0 and data holds.
//    Each entry produces exactly one one-cycle strobe.
//  - Latency: push at edge t -> grant in cycle t+1 -> O_WB_Index.v high in cycle t+2 (min 2 cycles).
//  - Ordering: FIFO order per requester; no ordering guarantee across requesters.
//    Same .idx from two pipes drains in grant order, so the last writer per RR is the final value.
//  - I_Stall or I_Buff_Full asserted: O_Grant='0, FIFOs keep filling up to DEPTH.
//    O_WB_Index.v falls to 0 the following cycle. An already-registered strobe is not retracted.
//  - Simultaneous push and pop on the same FIFO: count unchanged, pointers both advance. Pointers wrap mod DEPTH.
//  - Counts are clog2(DEPTH+1) bits and are never allowed to over- or underflow. Add an assertion for this.
// STRUCTURE
//  - pkg_tpu: reuse dst_t and data_t. Add localparam WB_NUM_REQ=3 and typedef wb_req_t {dst_t index; data_t data;}.
//  - Sub-module wb_req_fifo (DEPTH entries of wb_req_t: wr/rd ptr, count, ready, head), instanced NUM_REQ times.
//  - Top level: RR pointer register, rotate-priority pick over eligible bits, WB output register.
// TESTING
//  T1 reset: reset 2 cycles with pipes idle.
//     -> O_Req_Ready=3'b111, O_WB_Index.v=0, O_Busy=0.
//  T2 single: pipe0 pushes idx=5, data=0xA5 at edge t.
//     -> O_Grant=3'b001 in cycle t+1; O_WB_Index={v=1,idx=5}, data=0xA5 in t+2 only.
//  T3 round-robin: all three pipes push 2 entries at the same edge.
//     -> grants 001,010,100,001,010,100 on 6 consecutive cycles; 6 strobes; O_Busy falls after the last.
//  T4 backpressure: I_Buff_Full=1; pipe1 pushes 3 entries.
//     -> O_Req_Ready[1]=0 after 2 pushes, 3rd held, no grant.
//     Deassert full -> entries drain in push order.
//  T5 stall mid-drain: I_Stall pulses 1 cycle during T3.
//     -> one-cycle gap in grants, RR sequence resumes unchanged, no entry lost or duplicated.
//  T6 reset mid-operation: reset asserted with 4 queued entries.
//     -> no further strobes; O_Busy=0 and O_Req_Ready=111 the next cycle.

Source files
------------

// File: rtl/pkg_tpu.sv
// pkg_tpu: shared TPU lane types plus the write-back arbiter request entry
package pkg_tpu;
  localparam int DST_W = 5;
  localparam int DATA_W = 32;
  localparam int WB_NUM_REQ = 3;
  typedef struct packed {
    logic v;
    logic [DST_W-1:0] idx;
  } dst_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    dst_t index;
    data_t data;
  } wb_req_t;
endpackage

// File: rtl/wb_bypass_arbiter_fifo.sv
// wb_req_fifo: per-pipe request queue; ready/valid come from the registered count only
module wb_req_fifo
  import pkg_tpu::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    i_push,
  input  logic    i_pop,
  input  wb_req_t i_entry,
  output logic    o_ready,
  output logic    o_valid,
  output wb_req_t o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  wb_req_t r_mem [DEPTH];
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_ready = r_count != CW'(DEPTH);
  assign o_valid = r_count != '0;
  assign o_head = r_mem[r_rd];
  a_no_wrap: assert property (@(posedge clock) disable iff (reset)
    !(i_push && !o_ready) && !(i_pop && !o_valid));
endmodule

// File: rtl/wb_bypass_arbiter.sv
// wb_bypass_arbiter: round-robin drain of per-pipe FIFOs into one registered write-back port
module wb_bypass_arbiter
  import pkg_tpu::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               I_Stall,
  input  logic               I_Buff_Full,
  input  dst_t               I_Req_Index [NUM_REQ],
  input  data_t              I_Req_Data [NUM_REQ],
  output logic [NUM_REQ-1:0] O_Req_Ready,
  output dst_t               O_WB_Index,
  output data_t              O_WB_Data,
  output logic [NUM_REQ-1:0] O_Grant,
  output logic               O_Busy
);
  localparam int PW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] w_elig;
  wb_req_t w_head [NUM_REQ];
  wb_req_t w_entry [NUM_REQ];
  logic [PW-1:0] r_ptr, w_sel;
  logic w_found;
  dst_t r_wb_index;
  data_t r_wb_data;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    assign w_entry[i] = '{index: I_Req_Index[i], data: I_Req_Data[i]};
    wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (I_Req_Index[i].v & O_Req_Ready[i]),
      .i_pop   (O_Grant[i]),
      .i_entry (w_entry[i]),
      .o_ready (O_Req_Ready[i]),
      .o_valid (w_elig[i]),
      .o_head  (w_head[i])
    );
  end
  // first eligible pipe at or after the RR pointer, wrapping
  always_comb begin
    O_Grant = '0;
    w_sel = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && !I_Stall && !I_Buff_Full && w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
        O_Grant[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
        w_sel = PW'((int'(r_ptr) + k) % NUM_REQ);
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
      r_wb_index <= '0;
      r_wb_data <= '0;
    end else if (w_found) begin
      r_ptr <= w_sel == PW'(NUM_REQ - 1) ? '0 : w_sel + 1'b1;
      r_wb_index <= w_head[w_sel].index;
      r_wb_data <= w_head[w_sel].data;
    end else begin
      r_wb_index.v <= 1'b0;
    end
  end
  assign O_WB_Index = r_wb_index;
  assign O_WB_Data = r_wb_data;
  assign O_Busy = |w_elig | r_wb_index.v;
endmodule

// File: tb/tb_wb_bypass_arbiter.sv
// tb_wb_bypass_arbiter: directed scenarios for the write-back arbiter with hand-computed expectations
module tb_wb_bypass_arbiter;
  import pkg_tpu::*;
  logic clock = 1'b0;
  logic reset, stall, full;
  dst_t req_idx [3];
  data_t req_data [3];
  logic [2:0] ready, grant;
  dst_t wb_idx;
  data_t wb_data;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  wb_bypass_arbiter #(.NUM_REQ(3), .DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Stall     (stall),
    .I_Buff_Full (full),
    .I_Req_Index (req_idx),
    .I_Req_Data  (req_data),
    .O_Req_Ready (ready),
    .O_WB_Index  (wb_idx),
    .O_WB_Data   (wb_data),
    .O_Grant     (grant),
    .O_Busy      (busy)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle_pipes();
    for (int i = 0; i < 3; i++) begin
      req_idx[i] = '0;
      req_data[i] = '0;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    full = 1'b0;
    idle_pipes();
    repeat (2) tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready got=%b exp=111", ready); end
    n_chk++;
    if (wb_idx !== '0 || wb_data !== '0) begin n_fail++; $display("FAIL reset_wb got=%h/%h exp=0/0", wb_idx, wb_data); end
    n_chk++;
    if (busy !== 1'b0 || grant !== 3'b000) begin n_fail++; $display("FAIL reset_busy_grant got=%b/%b exp=0/000", busy, grant); end
  endtask
  task automatic test_single();
    dst_t e;
    e.v = 1'b1;
    e.idx = 5'd5;
    req_idx[0] = e;
    req_data[0] = 32'hA5;
    #1;
    tick();
    idle_pipes();
    #1;
    n_chk++;
    if (grant !== 3'b001 || wb_idx.v !== 1'b0) begin n_fail++; $display("FAIL single_grant got=%b v=%b exp=001 v=0", grant, wb_idx.v); end
    tick();
    n_chk++;
    if (wb_idx !== e || wb_data !== 32'hA5) begin n_fail++; $display("FAIL single_wb got=%h/%h exp=%h/a5", wb_idx, wb_data, e); end
    n_chk++;
    if (grant !== 3'b000) begin n_fail++; $display("FAIL single_no_regrant got=%b exp=000", grant); end
    tick();
    n_chk++;
    if (wb_idx.v !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after got v=%b busy=%b exp 0/0", wb_idx.v, busy); end
  endtask
  // pipe i pushes idx=i+1,data=0x10+i then idx=i+4,data=0x20+i; RR drain order gives idx 1..6
  task automatic test_drain(input int stall_c, input string name);
    int s, n;
    logic [2:0] exp_g, prev_g;
    dst_t e;
    data_t ed;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_idx[i] = '{v: 1'b1, idx: 5'(i + 1)};
      req_data[i] = 32'h10 + 32'(i);
    end
    tick();
    s = 0;
    n = 0;
    prev_g = '0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin
        for (int i = 0; i < 3; i++) begin
          req_idx[i] = '{v: 1'b1, idx: 5'(i + 4)};
          req_data[i] = 32'h20 + 32'(i);
        end
      end else idle_pipes();
      stall = c == stall_c;
      #1;
      exp_g = 3'b000;
      if (c != stall_c && s < 6) begin
        exp_g = 3'b001 << (s % 3);
        s++;
      end
      n_chk++;
      if (grant !== exp_g) begin n_fail++; $display("FAIL %s_grant c=%0d got=%b exp=%b", name, c, grant, exp_g); end
      n_chk++;
      if (wb_idx.v !== (prev_g != 0)) begin n_fail++; $display("FAIL %s_strobe c=%0d got=%b exp=%b", name, c, wb_idx.v, prev_g != 0); end
      if (prev_g != 0) begin
        e = '{v: 1'b1, idx: 5'(n + 1)};
        ed = n < 3 ? 32'h10 + 32'(n) : 32'h20 + 32'(n - 3);
        n_chk++;
        if (wb_idx !== e || wb_data !== ed) begin n_fail++; $display("FAIL %s_entry n=%0d got=%h/%h exp=%h/%h", name, n, wb_idx, wb_data, e, ed); end
        n++;
      end
      if (c == 8) begin
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end got=%b exp=0", name, busy); end
      end
      prev_g = grant;
      tick();
    end
    stall = 1'b0;
    n_chk++;
    if (n != 6) begin n_fail++; $display("FAIL %s_count got=%0d exp=6", name, n); end
  endtask
  task automatic test_backpressure();
    dst_t e [3];
    data_t d [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      e[k] = '{v: 1'b1, idx: 5'(7 + k)};
      d[k] = 32'h71 + 32'(k);
    end
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_idx[1] = e[k];
      req_data[1] = d[k];
      #1;
      n_chk++;
      if (ready[1] !== (k < 2) || grant !== 3'b000) begin n_fail++; $display("FAIL bp_fill k=%0d ready=%b grant=%b exp ready=%b grant=000", k, ready[1], grant, k < 2); end
      tick();
    end
    full = 1'b0;
    #1;
    n_chk++;
    if (grant !== 3'b010 || ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_release grant=%b ready=%b exp 010/0", grant, ready[1]); end
    tick();
    n_chk++;
    if (wb_idx !== e[0] || wb_data !== d[0] || grant !== 3'b010) begin n_fail++; $display("FAIL bp_drain0 got=%h/%h g=%b exp=%h/%h g=010", wb_idx, wb_data, grant, e[0], d[0]); end
    tick();
    idle_pipes();
    #1;
    n_chk++;
    if (wb_idx !== e[1] || wb_data !== d[1] || grant !== 3'b010) begin n_fail++; $display("FAIL bp_drain1 got=%h/%h g=%b exp=%h/%h g=010", wb_idx, wb_data, grant, e[1], d[1]); end
    tick();
    n_chk++;
    if (wb_idx !== e[2] || wb_data !== d[2] || grant !== 3'b000) begin n_fail++; $display("FAIL bp_drain2 got=%h/%h g=%b exp=%h/%h g=000", wb_idx, wb_data, grant, e[2], d[2]); end
    tick();
    n_chk++;
    if (wb_idx.v !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_done v=%b busy=%b exp 0/0", wb_idx.v, busy); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        req_idx[i] = '{v: 1'b1, idx: 5'(10 + 2 * i + k)};
        req_data[i] = 32'hC0 + 32'(2 * i + k);
      end
      tick();
    end
    idle_pipes();
    #1;
    n_chk++;
    if (ready !== 3'b100 || busy !== 1'b1) begin n_fail++; $display("FAIL rm_queued ready=%b busy=%b exp 100/1", ready, busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    full = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || ready !== 3'b111 || grant !== 3'b000) begin n_fail++; $display("FAIL rm_after busy=%b ready=%b grant=%b exp 0/111/000", busy, ready, grant); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (wb_idx.v !== 1'b0) begin n_fail++; $display("FAIL rm_no_strobe c=%0d got=%b exp=0", c, wb_idx.v); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_drain(-1, "rr");
    test_backpressure();
    test_drain(2, "stall");
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
